// File: rtl/reg_file_staged_pkg.sv
// Shared constants for the staged register file that feeds the ALU operand paths.
package reg_file_staged_pkg;

  // Default geometry: 8 registers of 8 bits each.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_NUM_REGS   = 2 ** DEF_ADDR_WIDTH;

  // Value every register and the staging entry take on reset.
  localparam logic [DEF_DATA_WIDTH-1:0] REG_RESET = 8'h00;

endpackage : reg_file_staged_pkg

// File: rtl/reg_file_staged_read_bypass.sv
// One read port: returns the staged write when it targets the addressed
// register, otherwise the committed array value. Purely combinational.
module reg_read_bypass
  import reg_file_staged_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  stg_valid,
  input  logic [ADDR_WIDTH-1:0] stg_addr,
  input  logic [DATA_WIDTH-1:0] stg_data,
  input  logic [DATA_WIDTH-1:0] arr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic hit_s;

  // Staging entry matches this port's address.
  always_comb begin
    hit_s = 1'b0;
    if (stg_valid && (stg_addr == rd_addr)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Select the newest value for the addressed register.
  always_comb begin
    rd_data = arr_data;
    if (hit_s) begin
      rd_data = stg_data;
    end else begin
      rd_data = arr_data;
    end
  end

endmodule : reg_read_bypass

// File: rtl/reg_file_staged.sv
// Register file with a one-entry write-back staging register. A write is
// captured into the staging entry at one edge and committed into the array
// at the next; both read ports bypass from the staging entry so the value
// is visible right after the capture edge.
module reg_file_staged
  import reg_file_staged_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic                  STALL,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  PENDING
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] RST_VAL = DATA_WIDTH'(REG_RESET);

  // Committed register array.
  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  // Staging entry holding the most recently captured write.
  logic                  stg_valid_r;
  logic [ADDR_WIDTH-1:0] stg_addr_r;
  logic [DATA_WIDTH-1:0] stg_data_r;

  // Next-state values for the staging entry.
  logic                  stg_valid_s;
  logic [ADDR_WIDTH-1:0] stg_addr_s;
  logic [DATA_WIDTH-1:0] stg_data_s;

  logic                  commit_en_s;
  logic                  capture_en_s;

  // Array read data for each port before bypass.
  logic [DATA_WIDTH-1:0] arr1_s;
  logic [DATA_WIDTH-1:0] arr2_s;

  // Decide whether this edge commits the staged write and captures a new one.
  always_comb begin
    commit_en_s  = 1'b0;
    capture_en_s = 1'b0;
    if (stg_valid_r) begin
      commit_en_s = 1'b1;
    end else begin
      commit_en_s = 1'b0;
    end
    if (WRITE && !STALL) begin
      capture_en_s = 1'b1;
    end else begin
      capture_en_s = 1'b0;
    end
  end

  // Staging next state: load on capture, otherwise invalidate and keep the
  // old address/data (they are ignored while invalid).
  always_comb begin
    stg_valid_s = 1'b0;
    stg_addr_s  = stg_addr_r;
    stg_data_s  = stg_data_r;
    if (capture_en_s) begin
      stg_valid_s = 1'b1;
      stg_addr_s  = INADDRESS;
      stg_data_s  = IN;
    end else begin
      stg_valid_s = 1'b0;
      stg_addr_s  = stg_addr_r;
      stg_data_s  = stg_data_r;
    end
  end

  // Staging register; reset discards any write in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stg_valid_r <= 1'b0;
      stg_addr_r  <= '0;
      stg_data_r  <= RST_VAL;
    end else begin
      stg_valid_r <= stg_valid_s;
      stg_addr_r  <= stg_addr_s;
      stg_data_r  <= stg_data_s;
    end
  end

  // Array write-back from the staging entry, one edge after capture.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RST_VAL;
      end
    end else if (commit_en_s) begin
      regs_r[stg_addr_r] <= stg_data_r;
    end else begin
      regs_r[stg_addr_r] <= regs_r[stg_addr_r];
    end
  end

  // Raw array lookups for the two read ports.
  always_comb begin
    arr1_s = regs_r[OUT1ADDRESS];
    arr2_s = regs_r[OUT2ADDRESS];
  end

  reg_read_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read1 (
    .rd_addr   (OUT1ADDRESS),
    .stg_valid (stg_valid_r),
    .stg_addr  (stg_addr_r),
    .stg_data  (stg_data_r),
    .arr_data  (arr1_s),
    .rd_data   (OUT1)
  );

  reg_read_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read2 (
    .rd_addr   (OUT2ADDRESS),
    .stg_valid (stg_valid_r),
    .stg_addr  (stg_addr_r),
    .stg_data  (stg_data_r),
    .arr_data  (arr2_s),
    .rd_data   (OUT2)
  );

  // PENDING comes straight from the staging flop, never from WRITE.
  assign PENDING = stg_valid_r;

endmodule : reg_file_staged

// File: tb/tb_reg_file_staged.sv
// Directed, table-driven bench for the staged register file.
module tb_reg_file_staged;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic       STALL;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic       PENDING;

  int n_vec;
  int n_err;

  typedef struct {
    logic       wr;
    logic       st;
    logic [2:0] ia;
    logic [7:0] din;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ep;
  } vec_t;

  vec_t vecs [16];

  reg_file_staged dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IN          (IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .STALL       (STALL),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .OUT1        (OUT1),
    .OUT2        (OUT2),
    .PENDING     (PENDING)
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic st, input logic [2:0] ia,
                       input logic [7:0] din, input logic [2:0] a1, input logic [2:0] a2);
    WRITE       = wr;
    STALL       = st;
    INADDRESS   = ia;
    IN          = din;
    OUT1ADDRESS = a1;
    OUT2ADDRESS = a2;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    RESET_N = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1);

    // Table: state starts from all zeros after the reset test below.
    vecs[0]  = '{1'b1, 1'b0, 3'd3, 8'hA5, 3'd3, 3'd0, 8'hA5, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd2, 8'h11, 3'd3, 3'd2, 8'hA5, 8'h11, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'd2, 8'h22, 3'd2, 3'd2, 8'h22, 8'h22, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 8'h22, 8'hA5, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd5, 8'h7F, 3'd5, 3'd2, 8'h7F, 8'h22, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 3'd5, 8'h01, 3'd5, 3'd5, 8'h7F, 8'h7F, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd0, 8'h7F, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'd4, 8'hC3, 3'd4, 3'd4, 8'hC3, 8'hC3, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 8'hC3, 8'hC3, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'd4, 8'h3C, 3'd4, 3'd4, 8'h3C, 8'h3C, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd3, 8'h3C, 8'hA5, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'd0, 8'h9E, 3'd0, 3'd1, 8'h9E, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 3'd1, 8'h42, 3'd0, 3'd1, 8'h9E, 8'h42, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 3'd7, 8'hFF, 3'd0, 3'd1, 8'h9E, 8'h42, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 3'd7, 8'h00, 3'd7, 3'd6, 8'hFF, 8'h00, 1'b0};

    // Reset held: outputs at zero.
    #12;
    chk("rst_held_out1", OUT1, 8'h00);
    chk("rst_held_out2", OUT2, 8'h00);
    chk("rst_held_pend", {7'd0, PENDING}, 8'h00);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Fill every register with 8'h55.
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      drive(1'b1, 1'b0, 3'(i), 8'h55, 3'(i), 3'd0);
      @(posedge CLK);
      #1;
      chk("fill_out1", OUT1, 8'h55);
    end
    chk("fill_pend", {7'd0, PENDING}, 8'h01);
    @(negedge CLK);
    drive(1'b1, 1'b0, 3'd6, 8'hAB, 3'd6, 3'd7);
    @(posedge CLK);
    #1;
    chk("fill_r6_bypass", OUT1, 8'hAB);
    chk("fill_r7_array", OUT2, 8'h55);

    // Mid-cycle reset pulse with a write in flight.
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_pulse_out1", OUT1, 8'h00);
    chk("rst_pulse_out2", OUT2, 8'h00);
    chk("rst_pulse_pend", {7'd0, PENDING}, 8'h00);
    WRITE = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i);
      #1;
      chk("post_rst_zero", OUT1, 8'h00);
    end

    // Table-driven vectors.
    for (int v = 0; v < 16; v++) begin
      @(negedge CLK);
      drive(vecs[v].wr, vecs[v].st, vecs[v].ia, vecs[v].din, vecs[v].a1, vecs[v].a2);
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_out1", v), OUT1, vecs[v].e1);
      chk($sformatf("vec%0d_out2", v), OUT2, vecs[v].e2);
      chk($sformatf("vec%0d_pend", v), {7'd0, PENDING}, {7'd0, vecs[v].ep});
    end

    // Write inputs alone must not reach the read ports before an edge.
    @(negedge CLK);
    drive(1'b1, 1'b0, 3'd3, 8'h5A, 3'd3, 3'd3);
    #1;
    chk("no_comb_out1", OUT1, 8'hA5);
    chk("no_comb_pend", {7'd0, PENDING}, 8'h00);
    @(posedge CLK);
    #1;
    chk("cap_r3_out1", OUT1, 8'h5A);

    // Reset before the commit edge of r6 = EE.
    @(negedge CLK);
    drive(1'b1, 1'b0, 3'd6, 8'hEE, 3'd6, 3'd7);
    @(posedge CLK);
    #1;
    chk("r6_staged", OUT1, 8'hEE);
    chk("r6_pend", {7'd0, PENDING}, 8'h01);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("r6_rst_out1", OUT1, 8'h00);
    chk("r6_rst_pend", {7'd0, PENDING}, 8'h00);
    WRITE = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("r6_after_rel", OUT1, 8'h00);
    chk("r7_after_rel", OUT2, 8'h00);
    chk("pend_after_rel", {7'd0, PENDING}, 8'h00);
    OUT1ADDRESS = 3'd3;
    #1;
    chk("r3_after_rel", OUT1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file_staged
